// File: rtl/taylor_pkg.sv
// Shared constants, types and helpers for the taylor_cos cosine engine.
// Build option: TAYLOR_ROUND_EN selects round-to-nearest products in fxp_mul
// (default build truncates).
package taylor_pkg;

   localparam int unsigned W      = 24;        // angle / result width, unsigned Q1.23
   localparam int unsigned FRAC   = 23;        // fractional bits
   localparam int unsigned NTERMS = 7;         // series terms x^0 .. x^12
   localparam int unsigned AW     = W + 2;     // signed accumulator width, Q2.23
   localparam int unsigned KW     = 3;         // Horner term counter width

   typedef logic signed [AW-1:0] acc_t;

   localparam acc_t ONE = acc_t'(1 << FRAC);

   // c[k] = (-1)^k / (2k)! rounded to Q2.23; c6 quantises to zero at this precision
   localparam acc_t COEF [0:NTERMS-1] = '{
      acc_t'(8388608),
      acc_t'(-4194304),
      acc_t'(349525),
      acc_t'(-11651),
      acc_t'(208),
      acc_t'(-2),
      acc_t'(0)
   };

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SQUARE = 2'd1,
      ST_HORNER = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Clamp a signed accumulator into the unsigned result range [0, 1.0]
   function automatic logic [W-1:0] sat_unit(input logic signed [AW-1:0] v);
      if (v < 0) begin
         return '0;
      end else if (v > ONE) begin
         return W'(ONE);
      end else begin
         return W'(v);
      end
   endfunction

endpackage

// File: rtl/taylor_cos_fxp_mul.sv
// fxp_mul: combinational signed fixed-point multiplier, result = (a*b) >> FRAC.
// Build option: TAYLOR_ROUND_EN adds half an LSB before the shift (round to
// nearest); otherwise the arithmetic shift floors.
// Ports:
//   a_in, b_in : signed Q2.23 operands
//   p_c        : signed Q2.23 scaled product (combinational)
module fxp_mul
   import taylor_pkg::*;
(
   input  logic signed [AW-1:0] a_in,
   input  logic signed [AW-1:0] b_in,
   output logic signed [AW-1:0] p_c
);

   localparam int unsigned PW = 2 * AW;

   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] prod_rnd;

   assign prod = PW'(a_in) * PW'(b_in);

   // Optional rounding offset ahead of the scaling shift
   always_comb begin
`ifdef TAYLOR_ROUND_EN
      prod_rnd = prod + PW'(1 << (FRAC - 1));
`else
      prod_rnd = prod;
`endif
   end

   // Operand ranges keep the scaled product inside AW bits
   assign p_c = AW'(prod_rnd >>> FRAC);

endmodule

// File: rtl/taylor_cos.sv
// taylor_cos: fixed-point cos(x) via a 7-term Maclaurin series in Horner form
// over x^2, sharing one fxp_mul between the squaring and Horner steps.
// Build option: TAYLOR_ROUND_EN (rounded products; default truncates).
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous active-high reset
//   start     : launches a computation when sampled high in IDLE
//   angle_in  : angle in radians, unsigned Q1.23, captured on accepted start
//   ready_out : result valid, high from completion until next accepted start
//   cos_out   : cos(angle), unsigned Q1.23, saturated to [0, 1.0]
module taylor_cos
   import taylor_pkg::*;
(
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] angle_in,
   output logic         ready_out,
   output logic [W-1:0] cos_out
);

   state_t               state_q, state_d;
   logic [W-1:0]         x_q, x_d;
   logic signed [AW-1:0] x2_q, x2_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic [KW-1:0]        k_q, k_d;
   logic                 ready_q, ready_d;
   logic [W-1:0]         cos_q, cos_d;

   logic signed [AW-1:0] mul_a, mul_b, mul_p;

   fxp_mul u_mul (
      .a_in (mul_a),
      .b_in (mul_b),
      .p_c  (mul_p)
   );

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (start) state_d = ST_SQUARE;
         ST_SQUARE: state_d = ST_HORNER;
         ST_HORNER: if (k_q == '0) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Datapath and output next values; multiplier operands default to x*x
   always_comb begin
      x_d     = x_q;
      x2_d    = x2_q;
      acc_d   = acc_q;
      k_d     = k_q;
      ready_d = ready_q;
      cos_d   = cos_q;
      mul_a   = AW'(x_q);
      mul_b   = AW'(x_q);
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               x_d     = angle_in;
               ready_d = 1'b0;
            end
         end
         ST_SQUARE: begin
            x2_d  = mul_p;
            acc_d = COEF[NTERMS-1];
            k_d   = KW'(NTERMS - 2);
         end
         ST_HORNER: begin
            mul_a = acc_q;
            mul_b = x2_q;
            acc_d = COEF[k_q] + mul_p;
            if (k_q != '0) k_d = k_q - KW'(1);
         end
         ST_DONE: begin
            cos_d   = sat_unit(acc_q);
            ready_d = 1'b1;
         end
         default: begin
            ready_d = ready_q;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x_q     <= '0;
         x2_q    <= '0;
         acc_q   <= '0;
         k_q     <= '0;
         ready_q <= 1'b0;
         cos_q   <= '0;
      end else begin
         x_q     <= x_d;
         x2_q    <= x2_d;
         acc_q   <= acc_d;
         k_q     <= k_d;
         ready_q <= ready_d;
         cos_q   <= cos_d;
      end
   end

   assign ready_out = ready_q;
   assign cos_out   = cos_q;

endmodule

// File: tb/tb_taylor_cos.sv
// Self-checking bench for taylor_cos: directed vector table, handshake corner
// sequences, an angle sweep and random angles against a reference model.
// Build option: TAYLOR_ROUND_EN changes the reference rounding and tolerances.
module tb_taylor_cos;

   logic        clock;
   logic        reset;
   logic        start;
   logic [23:0] angle_in;
   logic        ready_out;
   logic [23:0] cos_out;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef TAYLOR_ROUND_EN
   localparam longint TOL      = 3;
   localparam real    MEAN_LO  = -1.0;
`else
   localparam longint TOL      = 8;
   localparam real    MEAN_LO  = -8.0;
`endif
   localparam longint ONE_CODE = 64'sd8388608;

   longint coef [0:6];

   taylor_cos dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .angle_in  (angle_in),
      .ready_out (ready_out),
      .cos_out   (cos_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input longint act, input longint exp, input longint tol);
      n_cmp++;
      if (act > exp + tol || act < exp - tol) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (tol %0d)", name, act, exp, tol);
      end
   endtask

   // Series coefficients from the factorial definition, rounded to 23 fraction bits
   task automatic build_coefs();
      longint fact = 1;
      for (int k = 0; k < 7; k++) begin
         longint mag;
         if (k > 0) fact = fact * (2 * k - 1) * (2 * k);
         mag = (2 * ONE_CODE + fact) / (2 * fact);
         coef[k] = (k % 2 == 1) ? -mag : mag;
      end
   endtask

   function automatic longint scale(input longint p);
`ifdef TAYLOR_ROUND_EN
      return (p + 64'sd4194304) >>> 23;
`else
      return p >>> 23;
`endif
   endfunction

   // Horner evaluation of the truncated series in x^2, then clamp to [0, 1.0]
   function automatic longint model_cos(input longint x);
      longint x2, acc;
      x2  = scale(x * x);
      acc = coef[6];
      for (int k = 5; k >= 0; k--) acc = coef[k] + scale(acc * x2);
      if (acc < 0) return 0;
      if (acc > ONE_CODE) return ONE_CODE;
      return acc;
   endfunction

   function automatic longint true_cos(input longint x);
      real r;
      r = $cos(real'(x) / 8388608.0) * 8388608.0;
      return longint'($floor(r + 0.5));
   endfunction

   // One start pulse, then scramble angle_in; lat counts edges until ready rises
   task automatic run(input logic [23:0] a, output logic [23:0] res, output int lat);
      @(negedge clock);
      start    = 1'b1;
      angle_in = a;
      @(posedge clock);
      #1;
      start    = 1'b0;
      angle_in = 24'($urandom);
      lat = 0;
      while (!ready_out && lat < 30) begin
         @(posedge clock);
         #1;
         lat++;
      end
      res = cos_out;
   endtask

   typedef struct {
      logic [23:0] angle;
      longint      expv;
      longint      tol;
   } vec_t;

   initial begin
      vec_t        vecs [6];
      logic [23:0] res, res_b;
      int          lat, rises;
      logic [23:0] a, b;
      real         err_sum;
      int          err_n;
      real         mean;

      build_coefs();
      vecs[0] = '{24'd0,        ONE_CODE,                 0};
      vecs[1] = '{24'd838860,   64'sd8346700,             TOL};
      vecs[2] = '{24'd4194304,  64'sd7361696,             TOL};
      vecs[3] = '{24'd8388608,  64'sd4532384,             TOL};
      vecs[4] = '{24'd16777215, 64'sd0,                   0};
      vecs[5] = '{24'd13176795, model_cos(64'sd13176795), 0};

      reset    = 1'b1;
      start    = 1'b0;
      angle_in = '0;
      repeat (2) @(negedge clock);
      chk("reset_ready", longint'(ready_out), 0, 0);
      chk("reset_cos",   longint'(cos_out),   0, 0);
      reset = 1'b0;

      // Directed vectors
      foreach (vecs[i]) begin
         run(vecs[i].angle, res, lat);
         chk($sformatf("vec%0d_latency", i), lat, 8, 0);
         chk($sformatf("vec%0d_cos", i), longint'(res), vecs[i].expv, vecs[i].tol);
      end
      chk("pi2_small", longint'(res) <= 64 ? 1 : 0, 1, 0);

      // start during HORNER is ignored
      a = 24'd4194304;
      b = 24'd8388608;
      @(negedge clock);
      start = 1'b1; angle_in = a;
      @(posedge clock); #1;
      start = 1'b0; angle_in = b;
      repeat (3) @(posedge clock);
      @(negedge clock); start = 1'b1;
      @(posedge clock); #1; start = 1'b0;
      lat = 4;
      while (!ready_out && lat < 30) begin
         @(posedge clock); #1; lat++;
      end
      chk("busy_start_latency", lat, 8, 0);
      chk("busy_start_cos", longint'(cos_out), model_cos(longint'(a)), 0);
      rises = 0;
      repeat (12) begin
         @(posedge clock); #1;
         if (!ready_out) rises++;
      end
      chk("busy_start_no_rerun", rises, 0, 0);

      // Asynchronous reset mid-computation
      run(24'd0, res, lat);
      @(negedge clock);
      start = 1'b1; angle_in = 24'd4194304;
      @(posedge clock); #1; start = 1'b0;
      repeat (4) @(posedge clock);
      #2; reset = 1'b1;
      #1;
      chk("midreset_ready", longint'(ready_out), 0, 0);
      chk("midreset_cos",   longint'(cos_out),   0, 0);
      @(negedge clock); reset = 1'b0;
      rises = 0;
      repeat (12) begin
         @(posedge clock); #1;
         if (ready_out) rises++;
      end
      chk("midreset_no_ready", rises, 0, 0);
      run(24'd838860, res, lat);
      chk("after_reset_latency", lat, 8, 0);
      chk("after_reset_cos", longint'(res), model_cos(64'sd838860), 0);

      // start held high: back-to-back computations, angle sampled at each accept
      a = 24'd2097152;
      b = 24'd6291456;
      @(negedge clock);
      start = 1'b1; angle_in = a;
      @(posedge clock); #1; angle_in = b;
      lat = 0;
      while (!ready_out && lat < 30) begin
         @(posedge clock); #1; lat++;
      end
      chk("held_first_latency", lat, 8, 0);
      chk("held_first_cos", longint'(cos_out), model_cos(longint'(a)), 0);
      @(posedge clock); #1;
      chk("held_reaccept_ready_low", longint'(ready_out), 0, 0);
      start = 1'b0;
      lat = 0;
      while (!ready_out && lat < 30) begin
         @(posedge clock); #1; lat++;
      end
      chk("held_second_latency", lat, 8, 0);
      chk("held_second_cos", longint'(cos_out), model_cos(longint'(b)), 0);

      // Sweep 0 .. 1.57 rad; accuracy against true cosine up to 1.0 rad where
      // coefficient quantisation is negligible
      err_sum = 0.0;
      err_n   = 0;
      for (longint ang = 0; ang <= 64'sd13170115; ang += 64'sd838860) begin
         run(24'(ang), res, lat);
         chk($sformatf("sweep_%0d_latency", ang), lat, 8, 0);
         chk($sformatf("sweep_%0d_model", ang), longint'(res), model_cos(ang), 0);
         if (ang <= ONE_CODE) begin
            chk($sformatf("sweep_%0d_true", ang), longint'(res), true_cos(ang), TOL);
            err_sum += real'(longint'(res) - true_cos(ang));
            err_n++;
         end
      end
      mean = err_sum / real'(err_n);
      n_cmp++;
      if (mean < MEAN_LO || mean > 1.0) begin
         n_bad++;
         $display("FAIL sweep_mean_error: got %f want within [%f, 1.0]", mean, MEAN_LO);
      end

      // Random angles across the full input range
      for (int i = 0; i < 40; i++) begin
         a = 24'($urandom_range(0, 16777215));
         run(a, res, lat);
         chk($sformatf("rand%0d_latency", i), lat, 8, 0);
         chk($sformatf("rand%0d_model a=%0d", i, a), longint'(res), model_cos(longint'(a)), 0);
         if (longint'(a) <= ONE_CODE)
            chk($sformatf("rand%0d_true a=%0d", i, a), longint'(res), true_cos(longint'(a)), TOL);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
